// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
// Shared constants for the Y86-64 decode/forward slice:
//   - icode_e     : instruction codes HALT..POPQ
//   - REG_NONE    : register index meaning "no register" (never matches)
//   - REG_RSP     : stack pointer index used implicitly by call/ret/push/pop
//   - NOP_*       : field values of the nop bundle loaded into E on
//                   bubble or reset
//   - uses_valp() : icodes whose valA operand is the next PC
// ---------------------------------------------------------------------------
package y86_pkg;

    typedef enum logic [3:0] {
        HALT   = 4'h0,
        NOP    = 4'h1,
        RRMOVQ = 4'h2,
        IRMOVQ = 4'h3,
        RMMOVQ = 4'h4,
        MRMOVQ = 4'h5,
        OPQ    = 4'h6,
        JXX    = 4'h7,
        CALL   = 4'h8,
        RET    = 4'h9,
        PUSHQ  = 4'hA,
        POPQ   = 4'hB
    } icode_e;

    localparam logic [3:0] REG_NONE  = 4'hF;
    localparam logic [3:0] REG_RSP   = 4'h4;

    localparam logic [3:0] NOP_ICODE = 4'h1;
    localparam logic [3:0] NOP_IFUN  = 4'h0;
    localparam logic [3:0] NOP_IDX   = REG_NONE;

    // jXX and call carry the return/fall-through PC down the valA lane.
    function automatic logic uses_valp(input logic [3:0] icode);
        return (icode == JXX) || (icode == CALL);
    endfunction

endpackage

// File: rtl/dec_fwd_pipe_fwd_sel.sv
// ---------------------------------------------------------------------------
// fwd_sel
// Operand priority selector: picks the newest in-flight value for a source
// register index, or falls back to the register file read data.
//
// Ports:
//   src              in  RW : source register index being read
//   fwd_en           in  1  : 1 = use the forwarding chain, 0 = always rval
//   e_dst / e_val    in     : execute-stage ALU result (highest priority)
//   mm_dst / mm_val  in     : memory-stage load result
//   me_dst / me_val  in     : memory-stage ALU result
//   wm_dst / wm_val  in     : writeback load result
//   we_dst / we_val  in     : writeback ALU result (lowest priority)
//   rval             in  W  : register file read data for src
//   val              out W  : selected operand
// ---------------------------------------------------------------------------
module fwd_sel
    import y86_pkg::*;
#(
    parameter int W  = 64,
    parameter int RW = 4
) (
    input  logic [RW-1:0] src,
    input  logic          fwd_en,
    input  logic [RW-1:0] e_dst,
    input  logic [W-1:0]  e_val,
    input  logic [RW-1:0] mm_dst,
    input  logic [W-1:0]  mm_val,
    input  logic [RW-1:0] me_dst,
    input  logic [W-1:0]  me_val,
    input  logic [RW-1:0] wm_dst,
    input  logic [W-1:0]  wm_val,
    input  logic [RW-1:0] we_dst,
    input  logic [W-1:0]  we_val,
    input  logic [W-1:0]  rval,
    output logic [W-1:0]  val
);

    localparam logic [RW-1:0] IDX_NONE = RW'(REG_NONE);

    // A source of REG_NONE must not pick up a stage whose destination is
    // also REG_NONE, so the whole chain is gated on a real source index.
    logic src_real;

    always_comb begin
        src_real = (src != IDX_NONE);
        val      = rval;
        if (fwd_en && src_real) begin
            // Order matters: the youngest producer wins.
            if (src == e_dst) begin
                val = e_val;
            end else if (src == mm_dst) begin
                val = mm_val;
            end else if (src == me_dst) begin
                val = me_val;
            end else if (src == wm_dst) begin
                val = wm_val;
            end else if (src == we_dst) begin
                val = we_val;
            end
        end
    end

endmodule

// File: rtl/dec_fwd_pipe.sv
// ---------------------------------------------------------------------------
// dec_fwd_pipe
// Y86-64 decode stage with operand forwarding and the D->E pipeline register.
//
// Configuration macro: DEC_FWD_EN
//   defined   : operands are taken from the e/M/W forwarding chain
//   undefined : operands come straight from the register file; the forwarding
//               inputs have no effect and the hazard unit stalls instead
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   D_icode/D_ifun/D_rA/D_rB : decode-stage instruction fields
//   D_valC/D_valP            : constant word and next PC
//   srcA/srcB                : combinational register file read indices
//   rvalA/rvalB              : register file read data
//   e_dstE/e_valE            : execute-stage result
//   M_dstM/m_valM            : memory-stage load result
//   M_dstE/M_valE            : memory-stage ALU result
//   W_dstM/W_valM            : writeback load result
//   W_dstE/W_valE            : writeback ALU result
//   E_bubble                 : load a nop into E on the next edge
//   E_*                      : registered execute-stage bundle
// ---------------------------------------------------------------------------
module dec_fwd_pipe
    import y86_pkg::*;
#(
    parameter int W  = 64,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    D_icode,
    input  logic [3:0]    D_ifun,
    input  logic [RW-1:0] D_rA,
    input  logic [RW-1:0] D_rB,
    input  logic [W-1:0]  D_valC,
    input  logic [W-1:0]  D_valP,
    output logic [RW-1:0] srcA,
    output logic [RW-1:0] srcB,
    input  logic [W-1:0]  rvalA,
    input  logic [W-1:0]  rvalB,
    input  logic [RW-1:0] e_dstE,
    input  logic [W-1:0]  e_valE,
    input  logic [RW-1:0] M_dstM,
    input  logic [W-1:0]  m_valM,
    input  logic [RW-1:0] M_dstE,
    input  logic [W-1:0]  M_valE,
    input  logic [RW-1:0] W_dstM,
    input  logic [W-1:0]  W_valM,
    input  logic [RW-1:0] W_dstE,
    input  logic [W-1:0]  W_valE,
    input  logic          E_bubble,
    output logic [3:0]    E_icode,
    output logic [3:0]    E_ifun,
    output logic [W-1:0]  E_valC,
    output logic [W-1:0]  E_valA,
    output logic [W-1:0]  E_valB,
    output logic [RW-1:0] E_dstE,
    output logic [RW-1:0] E_dstM,
    output logic [RW-1:0] E_srcA,
    output logic [RW-1:0] E_srcB
);

    localparam logic [RW-1:0] IDX_NONE = RW'(REG_NONE);
    localparam logic [RW-1:0] IDX_RSP  = RW'(REG_RSP);
    localparam logic [RW-1:0] IDX_NOP  = RW'(NOP_IDX);

`ifdef DEC_FWD_EN
    localparam logic FWD_ON = 1'b1;
`else
    // Without forwarding the hazard unit holds dependent instructions in D
    // until the producer has written back, so the register file is current.
    localparam logic FWD_ON = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Decode: register indices
    // ------------------------------------------------------------------
    logic [RW-1:0] d_srcA;
    logic [RW-1:0] d_srcB;
    logic [RW-1:0] d_dstE;
    logic [RW-1:0] d_dstM;

    always_comb begin
        d_srcA = IDX_NONE;
        d_srcB = IDX_NONE;
        d_dstE = IDX_NONE;
        d_dstM = IDX_NONE;

        case (D_icode)
            RRMOVQ, RMMOVQ, OPQ, PUSHQ: d_srcA = D_rA;
            RET, POPQ:                  d_srcA = IDX_RSP;
            default:                    d_srcA = IDX_NONE;
        endcase

        case (D_icode)
            RMMOVQ, MRMOVQ, OPQ:        d_srcB = D_rB;
            CALL, RET, PUSHQ, POPQ:     d_srcB = IDX_RSP;
            default:                    d_srcB = IDX_NONE;
        endcase

        case (D_icode)
            RRMOVQ, IRMOVQ, OPQ:        d_dstE = D_rB;
            CALL, RET, PUSHQ, POPQ:     d_dstE = IDX_RSP;
            default:                    d_dstE = IDX_NONE;
        endcase

        case (D_icode)
            MRMOVQ, POPQ:               d_dstM = D_rA;
            default:                    d_dstM = IDX_NONE;
        endcase
    end

    // Read indices go out unregistered and ignore E_bubble: the register
    // file must be addressed by whatever sits in D this cycle.
    assign srcA = d_srcA;
    assign srcB = d_srcB;

    // ------------------------------------------------------------------
    // Decode: operand selection
    // ------------------------------------------------------------------
    logic [W-1:0] fwd_valA;
    logic [W-1:0] fwd_valB;
    logic [W-1:0] d_valA;
    logic [W-1:0] d_valB;

    fwd_sel #(.W(W), .RW(RW)) u_fwd_a (
        .src    (d_srcA),
        .fwd_en (FWD_ON),
        .e_dst  (e_dstE),
        .e_val  (e_valE),
        .mm_dst (M_dstM),
        .mm_val (m_valM),
        .me_dst (M_dstE),
        .me_val (M_valE),
        .wm_dst (W_dstM),
        .wm_val (W_valM),
        .we_dst (W_dstE),
        .we_val (W_valE),
        .rval   (rvalA),
        .val    (fwd_valA)
    );

    fwd_sel #(.W(W), .RW(RW)) u_fwd_b (
        .src    (d_srcB),
        .fwd_en (FWD_ON),
        .e_dst  (e_dstE),
        .e_val  (e_valE),
        .mm_dst (M_dstM),
        .mm_val (m_valM),
        .me_dst (M_dstE),
        .me_val (M_valE),
        .wm_dst (W_dstM),
        .wm_val (W_valM),
        .we_dst (W_dstE),
        .we_val (W_valE),
        .rval   (rvalB),
        .val    (fwd_valB)
    );

    always_comb begin
        d_valA = uses_valp(D_icode) ? D_valP : fwd_valA;
        d_valB = fwd_valB;
    end

    // ------------------------------------------------------------------
    // D -> E pipeline register
    // ------------------------------------------------------------------
    logic [3:0]    E_icode_d, E_icode_q;
    logic [3:0]    E_ifun_d,  E_ifun_q;
    logic [W-1:0]  E_valC_d,  E_valC_q;
    logic [W-1:0]  E_valA_d,  E_valA_q;
    logic [W-1:0]  E_valB_d,  E_valB_q;
    logic [RW-1:0] E_dstE_d,  E_dstE_q;
    logic [RW-1:0] E_dstM_d,  E_dstM_q;
    logic [RW-1:0] E_srcA_d,  E_srcA_q;
    logic [RW-1:0] E_srcB_d,  E_srcB_q;

    always_comb begin
        E_icode_d = D_icode;
        E_ifun_d  = D_ifun;
        E_valC_d  = D_valC;
        E_valA_d  = d_valA;
        E_valB_d  = d_valB;
        E_dstE_d  = d_dstE;
        E_dstM_d  = d_dstM;
        E_srcA_d  = d_srcA;
        E_srcB_d  = d_srcB;
        if (E_bubble) begin
            E_icode_d = NOP_ICODE;
            E_ifun_d  = NOP_IFUN;
            E_valC_d  = '0;
            E_valA_d  = '0;
            E_valB_d  = '0;
            E_dstE_d  = IDX_NOP;
            E_dstM_d  = IDX_NOP;
            E_srcA_d  = IDX_NOP;
            E_srcB_d  = IDX_NOP;
        end
    end

    // Reset clears data as well as control: a nop in E must not carry stale
    // operands downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            E_icode_q <= NOP_ICODE;
            E_ifun_q  <= NOP_IFUN;
            E_valC_q  <= '0;
            E_valA_q  <= '0;
            E_valB_q  <= '0;
            E_dstE_q  <= IDX_NOP;
            E_dstM_q  <= IDX_NOP;
            E_srcA_q  <= IDX_NOP;
            E_srcB_q  <= IDX_NOP;
        end else begin
            E_icode_q <= E_icode_d;
            E_ifun_q  <= E_ifun_d;
            E_valC_q  <= E_valC_d;
            E_valA_q  <= E_valA_d;
            E_valB_q  <= E_valB_d;
            E_dstE_q  <= E_dstE_d;
            E_dstM_q  <= E_dstM_d;
            E_srcA_q  <= E_srcA_d;
            E_srcB_q  <= E_srcB_d;
        end
    end

    assign E_icode = E_icode_q;
    assign E_ifun  = E_ifun_q;
    assign E_valC  = E_valC_q;
    assign E_valA  = E_valA_q;
    assign E_valB  = E_valB_q;
    assign E_dstE  = E_dstE_q;
    assign E_dstM  = E_dstM_q;
    assign E_srcA  = E_srcA_q;
    assign E_srcB  = E_srcB_q;

endmodule

// File: tb/tb_dec_fwd_pipe.sv
module tb_dec_fwd_pipe;

    localparam int W  = 64;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    D_icode, D_ifun;
    logic [RW-1:0] D_rA, D_rB;
    logic [W-1:0]  D_valC, D_valP;
    logic [RW-1:0] srcA, srcB;
    logic [W-1:0]  rvalA, rvalB;
    logic [RW-1:0] e_dstE, M_dstM, M_dstE, W_dstM, W_dstE;
    logic [W-1:0]  e_valE, m_valM, M_valE, W_valM, W_valE;
    logic          E_bubble;
    logic [3:0]    E_icode, E_ifun;
    logic [W-1:0]  E_valC, E_valA, E_valB;
    logic [RW-1:0] E_dstE, E_dstM, E_srcA, E_srcB;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dec_fwd_pipe #(.W(W), .RW(RW)) dut (
        .clk(clk), .rst(rst),
        .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP),
        .srcA(srcA), .srcB(srcB), .rvalA(rvalA), .rvalB(rvalB),
        .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstM(M_dstM), .m_valM(m_valM),
        .M_dstE(M_dstE), .M_valE(M_valE),
        .W_dstM(W_dstM), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_valE(W_valE),
        .E_bubble(E_bubble),
        .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
        if (ic inside {4'h9, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dstM(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h5, 4'hB}) return ra;
        return 4'hF;
    endfunction

    // Newest producer first; an absent source matches nothing.
    function automatic logic [63:0] m_pick(input logic [3:0] src, input logic [63:0] rv);
        if (src == 4'hF) return rv;
`ifdef DEC_FWD_EN
        begin
            logic [3:0]  dl [5];
            logic [63:0] vl [5];
            dl = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
            vl = '{e_valE, m_valM, M_valE, W_valM, W_valE};
            for (int i = 0; i < 5; i++)
                if (dl[i] == src) return vl[i];
        end
`endif
        return rv;
    endfunction

    // Apply current inputs for one clock, checking the comb indices before
    // the edge and the whole E bundle after it.
    task automatic step(input string tag);
        logic [3:0]  x_ic, x_if, x_de, x_dm, x_sa, x_sb;
        logic [63:0] x_vc, x_va, x_vb;
        #1;
        x_sa = m_srcA(D_icode, D_rA);
        x_sb = m_srcB(D_icode, D_rB);
        chk({tag, ".srcA"}, srcA, x_sa);
        chk({tag, ".srcB"}, srcB, x_sb);
        if (rst || E_bubble) begin
            x_ic = 4'h1; x_if = 4'h0; x_vc = '0; x_va = '0; x_vb = '0;
            x_de = 4'hF; x_dm = 4'hF; x_sa = 4'hF; x_sb = 4'hF;
        end else begin
            x_ic = D_icode; x_if = D_ifun; x_vc = D_valC;
            x_va = (D_icode inside {4'h7, 4'h8}) ? D_valP : m_pick(x_sa, rvalA);
            x_vb = m_pick(x_sb, rvalB);
            x_de = m_dstE(D_icode, D_rB);
            x_dm = m_dstM(D_icode, D_rA);
        end
        @(posedge clk);
        #1;
        chk({tag, ".E_icode"}, E_icode, x_ic);
        chk({tag, ".E_ifun"},  E_ifun,  x_if);
        chk({tag, ".E_valC"},  E_valC,  x_vc);
        chk({tag, ".E_valA"},  E_valA,  x_va);
        chk({tag, ".E_valB"},  E_valB,  x_vb);
        chk({tag, ".E_dstE"},  E_dstE,  x_de);
        chk({tag, ".E_dstM"},  E_dstM,  x_dm);
        chk({tag, ".E_srcA"},  E_srcA,  x_sa);
        chk({tag, ".E_srcB"},  E_srcB,  x_sb);
    endtask

    task automatic no_fwd();
        e_dstE = 4'hF; M_dstM = 4'hF; M_dstE = 4'hF; W_dstM = 4'hF; W_dstE = 4'hF;
    endtask

    task automatic set_d(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] vc, input logic [63:0] vp);
        D_icode = ic; D_ifun = fn; D_rA = ra; D_rB = rb; D_valC = vc; D_valP = vp;
    endtask

    initial begin
        rst = 1'b1; E_bubble = 1'b0;
        set_d(4'h3, 4'h0, 4'hF, 4'h5, 64'h1234, 64'h0A);
        rvalA = 64'h11; rvalB = 64'h22;
        e_valE = 64'hE0; m_valM = 64'hD0; M_valE = 64'hC0; W_valM = 64'hB0; W_valE = 64'hA0;
        no_fwd();
        @(negedge clk);

        // reset held two cycles
        step("rst0");
        step("rst1");
        chk("rst.lit_icode", E_icode, 64'h1);
        chk("rst.lit_dstE",  E_dstE,  64'hF);
        chk("rst.lit_valA",  E_valA,  64'h0);
        rst = 1'b0;

        // OPq, no forwarding match
        set_d(4'h6, 4'h1, 4'h2, 4'h3, 64'h0, 64'h2);
        rvalA = 64'h5; rvalB = 64'h7;
        step("opq");
        chk("opq.lit_valA", E_valA, 64'h5);
        chk("opq.lit_valB", E_valB, 64'h7);
        chk("opq.lit_dstE", E_dstE, 64'h3);

        // execute beats memory
        e_dstE = 4'h2; e_valE = 64'h10; M_dstE = 4'h2; M_valE = 64'h20;
        step("opq_fwd");
`ifdef DEC_FWD_EN
        chk("opq_fwd.lit_valA", E_valA, 64'h10);
`else
        chk("opq_fwd.lit_valA", E_valA, 64'h5);
`endif

        // priority among M/W stages on both lanes
        no_fwd();
        M_dstM = 4'h2; m_valM = 64'hA1; M_dstE = 4'h2; M_valE = 64'hA2;
        W_dstM = 4'h3; W_valM = 64'hB1; W_dstE = 4'h3; W_valE = 64'hB2;
        step("prio1");
        M_dstM = 4'hF; W_dstM = 4'hF;
        step("prio2");
        M_dstE = 4'hF;
        step("prio3");

        // pushq reads rsp via srcB, forwarded from writeback load
        no_fwd();
        set_d(4'hA, 4'h0, 4'h1, 4'hF, 64'h0, 64'h50);
        rvalB = 64'h77; W_dstM = 4'h4; W_valM = 64'h100;
        step("push");
        chk("push.lit_srcB", srcB, 64'h4);
`ifdef DEC_FWD_EN
        chk("push.lit_valB", E_valB, 64'h100);
`else
        chk("push.lit_valB", E_valB, 64'h77);
`endif

        // call: valA is next PC even with forwarding on rsp
        no_fwd();
        set_d(4'h8, 4'h0, 4'hF, 4'hF, 64'h99, 64'h40);
        M_dstE = 4'h4; M_valE = 64'h333;
        step("call");
        chk("call.lit_valA", E_valA, 64'h40);
        chk("call.lit_dstE", E_dstE, 64'h4);

        // absent source with absent destinations everywhere
        no_fwd();
        set_d(4'h3, 4'h0, 4'hF, 4'h6, 64'hABCD, 64'h0A);
        rvalA = 64'h123; rvalB = 64'h456;
        step("irmov_none");

        // popq, ret, mrmovq, jxx decode
        set_d(4'hB, 4'h0, 4'h7, 4'hF, 64'h0, 64'h2);
        W_dstE = 4'h4; W_valE = 64'h808;
        step("popq");
        set_d(4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1);
        step("ret");
        set_d(4'h5, 4'h0, 4'h8, 4'h9, 64'h18, 64'hA);
        e_dstE = 4'h9; e_valE = 64'h9090;
        step("mrmov");
        set_d(4'h7, 4'h3, 4'hF, 4'hF, 64'h2000, 64'h9);
        step("jxx");

        // bubble alone: srcA still decoded from D
        no_fwd();
        set_d(4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'h2);
        E_bubble = 1'b1;
        step("bubble");
        chk("bubble.lit_srcA",  srcA,    64'h2);
        chk("bubble.lit_icode", E_icode, 64'h1);

        // bubble and reset together, then resume
        set_d(4'h3, 4'h0, 4'hF, 4'h5, 64'h1234, 64'hA);
        rst = 1'b1;
        step("rst_bub");
        rst = 1'b0; E_bubble = 1'b0;
        step("resume");
        chk("resume.lit_icode", E_icode, 64'h3);
        chk("resume.lit_valC",  E_valC,  64'h1234);

        // reset mid-stream discards the instruction in D
        set_d(4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 64'h2);
        rst = 1'b1;
        step("rst_mid");
        rst = 1'b0;
        step("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
